// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory read port plus the IR valid/ready handshake.
interface fetch_unit_if #(
   parameter int unsigned WIDTH = 16
);
   logic             mem_rd;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_rdata;
   logic             ir_valid;
   logic             ir_ready;
   logic [WIDTH-1:0] ir_data;
   logic [WIDTH-1:0] ir_pc;

   // fetch unit side
   modport master (
      output mem_rd, mem_addr, ir_valid, ir_data, ir_pc,
      input  mem_rdata, ir_ready
   );

   // memory / core side
   modport slave (
      input  mem_rd, mem_addr, ir_valid, ir_data, ir_pc,
      output mem_rdata, ir_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word reads into a small prefetch queue,
// presented to the core over valid/ready, with redirect and halt control.
module fetch_unit #(
   parameter int unsigned      WIDTH    = 16,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  redirect,
   input  logic [WIDTH-1:0]      redirect_pc,
   input  logic                  halt,
   fetch_unit_if.master          bus,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = CW + 1;

   typedef struct packed {
      logic [WIDTH-1:0] word;
      logic [WIDTH-1:0] pc;
   } entry_t;

   entry_t           queue_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] fpc_q, fpc_d;
   logic [WIDTH-1:0] infl_pc_q;
   logic             infl_q;
   logic             issue;
   logic             push;
   logic             pop;

   // Issue/push/pop decisions and next-state; a same-cycle pop is not credited
   // toward issue space, so the outstanding read always has a free slot.
   always_comb begin
      issue   = !reset && !redirect && !halt &&
                ((SW'(count_q) + SW'(infl_q)) < SW'(DEPTH));
      push    = infl_q && !redirect;
      pop     = (count_q != '0) && bus.ir_ready && !redirect;
      fpc_d   = fpc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (redirect) begin
         fpc_d   = redirect_pc;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (issue) fpc_d  = fpc_q + WIDTH'(1);
         if (push)  tail_d = tail_q + PW'(1);
         if (pop)   head_d = head_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // State registers and queue storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         fpc_q     <= RESET_PC;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         infl_q    <= 1'b0;
         infl_pc_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) queue_q[PW'(i)] <= '0;
      end else begin
         fpc_q   <= fpc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         infl_q  <= issue;
         if (issue) infl_pc_q <= fpc_q;
         if (push)  queue_q[tail_q] <= '{word: bus.mem_rdata, pc: infl_pc_q};
      end
   end

   assign bus.mem_rd   = issue;
   assign bus.mem_addr = fpc_q;
   assign bus.ir_valid = (count_q != '0);
   assign bus.ir_data  = queue_q[head_q].word;
   assign bus.ir_pc    = queue_q[head_q].pc;
   assign count        = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences,
// and a randomized run against a sequential-stream reference model.
module tb_fetch_unit;
   localparam int unsigned W   = 16;
   localparam int unsigned D   = 4;
   localparam logic [15:0] RPC = 16'h0010;
   localparam logic [15:0] KEY = 16'hA5A5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic [2:0]  count;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] got[$];

   fetch_unit_if #(.WIDTH(W)) bus ();

   fetch_unit #(.WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .bus         (bus),
      .count       (count)
   );

   always #5 clk = ~clk;

   // instruction memory: word[a] = a ^ KEY, one-cycle read latency
   always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= bus.mem_addr ^ KEY;

   typedef struct {
      logic        rs, rd;
      logic [15:0] rp;
      logic        rdy;
      logic        e_rd;
      logic [15:0] e_addr;
      logic        e_v;
      logic [15:0] e_pc;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t tv [19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // one clock: drive after the edge, sample at the falling edge, log deliveries
   task automatic cyc(input logic rs, input logic rd, input logic [15:0] rp,
                      input logic h, input logic rdy);
      @(posedge clk); #1;
      reset = rs; redirect = rd; redirect_pc = rp; halt = h; bus.ir_ready = rdy;
      @(negedge clk);
      if (!rs && !rd && bus.ir_valid && rdy) begin
         got.push_back(bus.ir_pc);
         chk("deliv_data", 32'(bus.ir_data), 32'(bus.ir_pc ^ KEY));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] ef, ed;
      int          ndel;
      logic        rs, rd, h, rdy;
      logic [15:0] rp;

      bus.ir_ready = 1'b1;
      //         rs rd rp       rdy e_rd e_addr    e_v e_pc      e_cnt
      tv[0]  = '{1, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 3'd0};
      tv[1]  = '{0, 0, 16'h0000, 1, 1, 16'h0010, 0, 16'h0000, 3'd0};
      tv[2]  = '{0, 0, 16'h0000, 1, 1, 16'h0011, 0, 16'h0000, 3'd0};
      tv[3]  = '{0, 0, 16'h0000, 1, 1, 16'h0012, 1, 16'h0010, 3'd1};
      tv[4]  = '{0, 0, 16'h0000, 1, 1, 16'h0013, 1, 16'h0011, 3'd1};
      tv[5]  = '{0, 0, 16'h0000, 1, 1, 16'h0014, 1, 16'h0012, 3'd1};
      tv[6]  = '{0, 1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0013, 3'd1};
      tv[7]  = '{0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 3'd0};
      tv[8]  = '{0, 0, 16'h0000, 0, 1, 16'h0001, 0, 16'h0000, 3'd0};
      tv[9]  = '{0, 0, 16'h0000, 0, 1, 16'h0002, 1, 16'h0000, 3'd1};
      tv[10] = '{0, 0, 16'h0000, 0, 1, 16'h0003, 1, 16'h0000, 3'd2};
      tv[11] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 3'd3};
      tv[12] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 3'd4};
      tv[13] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 3'd4};
      tv[14] = '{0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0000, 3'd4};
      tv[15] = '{0, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'h0001, 3'd3};
      tv[16] = '{0, 0, 16'h0000, 1, 1, 16'h0005, 1, 16'h0002, 3'd2};
      tv[17] = '{0, 0, 16'h0000, 1, 1, 16'h0006, 1, 16'h0003, 3'd2};
      tv[18] = '{0, 0, 16'h0000, 1, 1, 16'h0007, 1, 16'h0004, 3'd2};

      // power-on reset
      cyc(1, 0, 16'h0, 0, 1);
      cyc(1, 0, 16'h0, 0, 1);
      chk("rst_valid", 32'(bus.ir_valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ir_pc", 32'(bus.ir_pc), 0);
      chk("rst_ir_data", 32'(bus.ir_data), 0);
      chk("rst_mem_rd", 32'(bus.mem_rd), 0);

      // vector table: stream from reset, redirect, backpressure fill and release
      for (int i = 0; i < 19; i++) begin
         cyc(tv[i].rs, tv[i].rd, tv[i].rp, 1'b0, tv[i].rdy);
         chk($sformatf("tv%0d_mem_rd", i), 32'(bus.mem_rd), 32'(tv[i].e_rd));
         if (tv[i].e_rd) chk($sformatf("tv%0d_mem_addr", i), 32'(bus.mem_addr), 32'(tv[i].e_addr));
         chk($sformatf("tv%0d_valid", i), 32'(bus.ir_valid), 32'(tv[i].e_v));
         if (tv[i].e_v) chk($sformatf("tv%0d_ir_pc", i), 32'(bus.ir_pc), 32'(tv[i].e_pc));
         chk($sformatf("tv%0d_count", i), 32'(count), 32'(tv[i].e_cnt));
      end

      // redirect while 3 entries are queued and a read is in flight
      cyc(0, 1, 16'h0200, 0, 0);
      repeat (4) cyc(0, 0, 16'h0, 0, 0);
      cyc(0, 1, 16'h0100, 0, 0);
      chk("redir_pre_count", 32'(count), 3);
      got.delete();
      cyc(0, 0, 16'h0, 0, 1);
      chk("redir_r1_valid", 32'(bus.ir_valid), 0);
      chk("redir_r1_count", 32'(count), 0);
      chk("redir_r1_mem_rd", 32'(bus.mem_rd), 1);
      chk("redir_r1_addr", 32'(bus.mem_addr), 32'h0100);
      cyc(0, 0, 16'h0, 0, 1);
      chk("redir_r2_valid", 32'(bus.ir_valid), 0);
      cyc(0, 0, 16'h0, 0, 1);
      chk("redir_r3_valid", 32'(bus.ir_valid), 1);
      chk("redir_r3_pc", 32'(bus.ir_pc), 32'h0100);
      repeat (3) cyc(0, 0, 16'h0, 0, 1);
      chk("redir_ndeliv", 32'(got.size()), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("redir_seq%0d", i), 32'(got[i]), 32'h0100 + 32'(i));

      // address wrap from 0xFFFE
      cyc(0, 1, 16'hFFFE, 0, 1);
      got.delete();
      repeat (6) cyc(0, 0, 16'h0, 0, 1);
      chk("wrap_ndeliv", 32'(got.size()), 4);
      chk("wrap_seq0", 32'(got[0]), 32'hFFFE);
      chk("wrap_seq1", 32'(got[1]), 32'hFFFF);
      chk("wrap_seq2", 32'(got[2]), 32'h0000);
      chk("wrap_seq3", 32'(got[3]), 32'h0001);

      // halt for 5 cycles: no reads, queue drains, then seamless resume
      got.delete();
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 16'h0, 1, 1);
         chk($sformatf("halt%0d_mem_rd", i), 32'(bus.mem_rd), 0);
      end
      chk("halt_drained", 32'(count), 0);
      repeat (6) cyc(0, 0, 16'h0, 0, 1);
      chk("halt_ndeliv", 32'(got.size()), 6);
      chk("halt_first", 32'(got[0]), 32'h0002);
      for (int i = 1; i < got.size(); i++)
         chk($sformatf("halt_seq%0d", i), 32'(got[i]), 32'(got[0] + 16'(i)));

      // reset one cycle after an issue to 0x0042
      cyc(0, 1, 16'h0042, 0, 1);
      cyc(0, 0, 16'h0, 0, 1);
      chk("rmid_issue", 32'(bus.mem_rd), 1);
      chk("rmid_addr", 32'(bus.mem_addr), 32'h0042);
      cyc(1, 0, 16'h0, 0, 1);
      chk("rmid_rst_mem_rd", 32'(bus.mem_rd), 0);
      cyc(0, 0, 16'h0, 0, 1);
      chk("rmid_c0_valid", 32'(bus.ir_valid), 0);
      chk("rmid_c0_count", 32'(count), 0);
      chk("rmid_c0_addr", 32'(bus.mem_addr), 32'(RPC));
      cyc(0, 0, 16'h0, 0, 1);
      chk("rmid_c1_valid", 32'(bus.ir_valid), 0);
      cyc(0, 0, 16'h0, 0, 1);
      chk("rmid_c2_valid", 32'(bus.ir_valid), 1);
      chk("rmid_c2_pc", 32'(bus.ir_pc), 32'(RPC));

      // randomized run: fetch and delivery must each be gap-free sequential
      // streams restarting at redirect_pc / RESET_PC
      ef = '0; ed = '0; ndel = 0;
      for (int n = 0; n < 3000; n++) begin
         rs  = (n != 0) && ($urandom_range(63) == 0);
         rd  = (n == 0) || ($urandom_range(15) == 0);
         rp  = 16'($urandom);
         h   = ($urandom_range(4) == 0);
         rdy = ($urandom_range(2) != 0);
         cyc(rs, rd, rp, h, rdy);
         if (rs) begin
            chk("rnd_rst_mem_rd", 32'(bus.mem_rd), 0);
            ef = RPC; ed = RPC;
         end else if (rd) begin
            chk("rnd_redir_mem_rd", 32'(bus.mem_rd), 0);
            ef = rp; ed = rp;
         end else begin
            if (bus.ir_valid && rdy) begin
               chk("rnd_ir_pc", 32'(bus.ir_pc), 32'(ed));
               ed = ed + 16'd1;
               ndel++;
            end
            if (bus.mem_rd) begin
               chk("rnd_mem_addr", 32'(bus.mem_addr), 32'(ef));
               ef = ef + 16'd1;
            end
            if (h) chk("rnd_halt_mem_rd", 32'(bus.mem_rd), 0);
         end
         chk("rnd_valid_vs_count", 32'(bus.ir_valid), 32'(count != 3'd0));
         chk("rnd_count_bound", 32'(count <= 3'(D)), 1);
      end
      chk("rnd_liveness", 32'(ndel > 300), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
